timer_arbiter: RTL and testbench
================================

Name: timer_arbiter

Overview:
- Shares one interval counter among NREQ requesters (e.g. per-colour RGB hold/fade timers).
- Round-robin arbiter grants the counter to one requester at a time.
- Loads that requester's duration, counts it down, and returns a one-cycle done pulse to the owner.
- Sits between the RGB sequencing logic and the PWM/timer datapath, replacing per-channel free-running timers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, counter/duration width in bits.
- PRESCALE, 8, cycles per count decrement; used only when TIMER_ARB_PRESCALE_EN is defined; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester service request, level; hold high until done or abandon.
- dur  input  NREQ*W  packed durations; requester i uses dur[i*W +: W].
- gnt  output  NREQ  one-hot current owner; all-zero when idle.
- done  output  NREQ  one-cycle pulse to the owner at interval expiry.
- busy  output  1  high while a grant is active (RUN state).
- count  output  W  current remaining count; 0 when idle.

Behaviour:
- Reset (async, while reset high):
  - state=IDLE; gnt=0, done=0, busy=0, count=0; RR pointer ptr=0; prescaler=0.
  - Reset asserted mid-RUN aborts silently; no done pulse is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If req != 0, pick the winner: the first set bit searching ptr, ptr+1, …, wrapping modulo NREQ.
  - At the clock edge: gnt=onehot(winner), count=dur[winner] (sampled here only), busy=1, go to RUN.
  - If req == 0, stay in IDLE.
- RUN:
  - If req[winner]==0 (abandon): next edge gnt=0, busy=0, count=0, ptr=winner+1 (mod NREQ), go to IDLE. No done pulse.
  - Else if count==0 (and, with prescale, tick==1): next edge gnt=0, busy=0, done[winner]=1, go to DONE.
  - Else: count decrements by 1 per cycle (per tick with prescale).
- DONE:
  - done is high for exactly this one cycle; ptr=winner+1 (mod NREQ); go to IDLE.
- Latency without prescale:
  - req seen at edge k → gnt high for cycles k+1 … k+1+dur (dur+1 cycles).
  - done high in cycle k+2+dur.
  - Earliest next grant in cycle k+4+dur.
- dur=0: gnt for exactly 1 cycle, then done.
- dur=2^W-1: no overflow; count is only decremented, never incremented.
- Simultaneous requests: strictly round-robin. The winner moves to lowest priority after done or abandon.
- Changes to dur[winner] during RUN are ignored. Changes to other requesters' req/dur have no effect until IDLE.
- A requester re-raising req immediately after its own done is re-served only after the others pending (RR fairness).
- gnt, done and busy are registered outputs with no combinational path from inputs.
- Invariants: gnt and done are never nonzero in the same cycle; at most one bit of each is set.

Optional Feature:
- Macro: TIMER_ARB_PRESCALE_EN.
- Defined:
  - A prescaler counter (width clog2(PRESCALE)) clears at grant.
  - It produces tick=1 every PRESCALE cycles of RUN.
  - count decrements and the expiry check happen only on tick.
  - Grant length = (dur+1)*PRESCALE cycles.
- Undefined:
  - No prescaler logic; tick is constant 1; PRESCALE is ignored.

Test Plan:
1. Single requester: req=4'b0001, dur0=3 → gnt=0001 for 4 cycles, then done=0001 for 1 cycle, busy low after; count shows 3,2,1,0.
2. All four request, dur all =1 from reset → grants in order 0,1,2,3, each 2 cycles; done pulses in the same order; no overlap of gnt and done.
3. Abandon: req0 with dur=10, drop req0 after 3 grant cycles → gnt clears the next edge, no done; the next grant goes to requester 1 if pending.
4. Edge durations: dur=0 → 1-cycle grant; dur=16'hFFFF → grant lasts 65536 cycles with no wrap; done fires once.
5. Reset mid-RUN: assert reset at cycle 5 of dur=20 → gnt/done/busy/count are 0 immediately (async); after release, req1 is served first-available from ptr=0.
6. With TIMER_ARB_PRESCALE_EN, PRESCALE=8, dur=2 → gnt high 24 cycles, count steps every 8 cycles, done at cycle 25 after grant start.

Source files
------------

// File: rtl/timer_arbiter.sv
// ============================================================================
// timer_arbiter: one shared interval counter, granted round-robin to NREQ
// requesters; one-cycle done pulse at expiry. Optional: TIMER_ARB_PRESCALE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module timer_arbiter #(
  parameter int NREQ     = 4,
  parameter int W        = 16,
  parameter int PRESCALE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] dur,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [W-1:0]      count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [PW-1:0]       ptr, ptr_next;
  logic [PW-1:0]       owner, owner_next;
  logic [PW-1:0]       owner_inc;
  logic [PW-1:0]       pick;
  logic                found;
  logic [NREQ-1:0]     gnt_next, done_next;
  logic                busy_next;
  logic [W-1:0]        count_next;
  logic                tick;

  if (NREQ < 2 || NREQ > 8 || PRESCALE < 1) begin : g_param_check
    $error("timer_arbiter: NREQ must be 2..8 and PRESCALE >= 1");
  end

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    int j;
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        pick  = PW'(j);
        found = 1'b1;
      end
    end
  end

  assign owner_inc = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;

`ifdef TIMER_ARB_PRESCALE_EN
  localparam int SW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [SW-1:0] presc;

  assign tick = (PRESCALE <= 1) || (presc == SW'(PRESCALE - 1));

  // Held at zero outside RUN, so every grant starts a fresh prescale period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      presc <= '0;
    else if (state != S_RUN || tick)
      presc <= '0;
    else
      presc <= presc + 1'b1;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    owner_next = owner;
    gnt_next   = gnt;
    done_next  = '0;
    busy_next  = busy;
    count_next = count;
    case (state)
      S_IDLE: begin
        if (found) begin
          owner_next = pick;
          gnt_next   = onehot(pick);
          count_next = dur[pick*W +: W];
          busy_next  = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!req[owner]) begin
          gnt_next   = '0;
          busy_next  = 1'b0;
          count_next = '0;
          ptr_next   = owner_inc;
          state_next = S_IDLE;
        end else if (tick) begin
          if (count == '0) begin
            gnt_next   = '0;
            busy_next  = 1'b0;
            done_next  = onehot(owner);
            state_next = S_DONE;
          end else begin
            count_next = count - 1'b1;
          end
        end
      end
      S_DONE: begin
        ptr_next   = owner_inc;
        state_next = S_IDLE;
      end
      default: begin
        gnt_next   = '0;
        busy_next  = 1'b0;
        count_next = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ptr   <= '0;
      owner <= '0;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      count <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      owner <= owner_next;
      gnt   <= gnt_next;
      done  <= done_next;
      busy  <= busy_next;
      count <= count_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_timer_arbiter.sv
// ============================================================================
// tb_timer_arbiter: directed literal checks plus randomized traffic compared
// every cycle against a transaction-level model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_timer_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;
`ifdef TIMER_ARB_PRESCALE_EN
  localparam int P = 8;
`else
  localparam int P = 1;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] dur = '0;
  logic [NREQ-1:0]   gnt, done;
  logic              busy;
  logic [W-1:0]      count;

  int vectors = 0;
  int miscompares = 0;

  timer_arbiter #(.NREQ(NREQ), .W(W), .PRESCALE(8)) dut (
    .clk(clk), .reset(reset), .req(req), .dur(dur),
    .gnt(gnt), .done(done), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  // Model: who owns the timer, who is being told "done", and the remaining count.
  typedef struct {
    int           owner;
    int           pulse;
    int           ptr;
    int           sub;
    logic [W-1:0] cnt;
  } mstate_t;

  mstate_t m = '{owner: -1, pulse: -1, ptr: 0, sub: 0, cnt: '0};

  function automatic mstate_t step(input mstate_t s, input logic [NREQ-1:0] r,
                                   input logic [NREQ*W-1:0] d);
    mstate_t n = s;
    int w;
    if (s.pulse >= 0) begin
      n.ptr   = (s.pulse + 1) % NREQ;
      n.pulse = -1;
    end else if (s.owner >= 0) begin
      n.sub = s.sub + 1;
      if (!r[s.owner]) begin
        n.ptr   = (s.owner + 1) % NREQ;
        n.owner = -1;
        n.cnt   = '0;
      end else if ((s.sub % P) == P - 1) begin
        if (s.cnt == 0) begin
          n.pulse = s.owner;
          n.owner = -1;
        end else begin
          n.cnt = s.cnt - 1'b1;
        end
      end
    end else if (r != 0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && r[(s.ptr + k) % NREQ]) w = (s.ptr + k) % NREQ;
      n.owner = w;
      n.cnt   = d[w*W +: W];
      n.sub   = 0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '{owner: -1, pulse: -1, ptr: 0, sub: 0, cnt: '0};
    else       m <= step(m, req, dur);
  end

  function automatic logic [NREQ-1:0] bit_of(input int i);
    return (i >= 0) ? (NREQ'(1) << i) : '0;
  endfunction

  always @(negedge clk) begin
    vectors++;
    if (gnt !== bit_of(m.owner) || done !== bit_of(m.pulse) ||
        busy !== (m.owner >= 0) || count !== m.cnt) begin
      miscompares++;
      $display("FAIL model t=%0t gnt=%b want %b done=%b want %b busy=%b want %b count=%0d want %0d",
               $time, gnt, bit_of(m.owner), done, bit_of(m.pulse),
               busy, (m.owner >= 0), count, m.cnt);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    dur   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic random_step();
    for (int i = 0; i < NREQ; i++) begin
      if (!req[i]) begin
        if ($urandom_range(3) == 0) begin
          req[i] = 1'b1;
          dur[i*W +: W] = ($urandom_range(15) == 0) ? W'(40) : W'($urandom_range(6));
        end
      end else if (m.pulse == i) begin
        if ($urandom_range(3) != 0) req[i] = 1'b0;
      end else if ($urandom_range(59) == 0) begin
        req[i] = 1'b0;
      end
    end
    if ($urandom_range(7) == 0) begin
      int j;
      j = int'($urandom_range(NREQ - 1));
      dur[j*W +: W] = W'($urandom_range(9));
    end
  endtask

  logic [3:0] t2_gnt  [16] = '{1,1,0,0, 2,2,0,0, 4,4,0,0, 8,8,0,0};
  logic [3:0] t2_done [16] = '{0,0,1,0, 0,0,2,0, 0,0,4,0, 0,0,8,0};

  initial begin
    int glen;
    int dat;
    bit seen;

`ifndef TIMER_ARB_PRESCALE_EN
    // Single requester, dur=3: count 3,2,1,0 then done.
    do_reset();
    req = 4'b0001; dur[0 +: W] = 16'd3;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_count", 32'(count), 32'(3 - c));
    end
    @(negedge clk);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_gnt_off", 32'(gnt), 32'h0);
    req = '0;
    @(negedge clk);
    chk("t1_busy_off", 32'(busy), 32'h0);

    // All four pending, dur=1: strict rotation 0,1,2,3.
    do_reset();
    req = 4'hF;
    for (int i = 0; i < NREQ; i++) dur[i*W +: W] = 16'd1;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      chk("t2_gnt", 32'(gnt), 32'(t2_gnt[t]));
      chk("t2_done", 32'(done), 32'(t2_done[t]));
      req = req & ~t2_done[t];
    end

    // Abandon after three grant cycles hands over to requester 1.
    do_reset();
    req = 4'b0011; dur[0 +: W] = 16'd10; dur[W +: W] = 16'd2;
    repeat (3) begin
      @(negedge clk);
      chk("t3_gnt0", 32'(gnt), 32'h1);
    end
    req[0] = 1'b0;
    @(negedge clk);
    chk("t3_abandon_gnt", 32'(gnt), 32'h0);
    chk("t3_abandon_done", 32'(done), 32'h0);
    @(negedge clk);
    chk("t3_next_gnt", 32'(gnt), 32'h2);
    chk("t3_next_count", 32'(count), 32'd2);

    // dur=0 gives a single grant cycle; dur=FFFF runs 65536 cycles without wrap.
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    chk("t4_zero_gnt", 32'(gnt), 32'h4);
    @(negedge clk);
    chk("t4_zero_done", 32'(done), 32'h4);
    req = '0;
    @(negedge clk);
    req = 4'b1000; dur[3*W +: W] = 16'hFFFF;
    @(negedge clk);
    chk("t4_max_count", 32'(count), 32'hFFFF);
    glen = 1; seen = 1'b0;
    for (int c = 0; c < 70000 && !seen; c++) begin
      @(negedge clk);
      if (gnt == 4'b1000) glen++;
      if (done == 4'b1000) seen = 1'b1;
    end
    chk("t4_max_len", 32'(glen), 32'd65536);
    chk("t4_max_done", 32'(seen), 32'h1);
    req = '0;

    // Async reset mid-run clears outputs immediately; ptr restarts at 0.
    do_reset();
    req = 4'b0010; dur[W +: W] = 16'd20;
    repeat (5) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t5_gnt", 32'(gnt), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_count", 32'(count), 32'h0);
    chk("t5_done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_regrant", 32'(gnt), 32'h2);
    chk("t5_recount", 32'(count), 32'd20);
    req = '0;
`else
    // Prescale 8, dur=2: 24 grant cycles, count steps every 8, done in cycle 25.
    do_reset();
    req = 4'b0010; dur[W +: W] = 16'd2;
    glen = 0; dat = 0; seen = 1'b0;
    for (int c = 1; c <= 200 && !seen; c++) begin
      @(negedge clk);
      if (gnt == 4'b0010) glen++;
      if (c == 1)  chk("t6_count_a", 32'(count), 32'd2);
      if (c == 9)  chk("t6_count_b", 32'(count), 32'd1);
      if (c == 17) chk("t6_count_c", 32'(count), 32'd0);
      if (done == 4'b0010) begin
        seen = 1'b1;
        dat  = c;
      end
    end
    chk("t6_len", 32'(glen), 32'd24);
    chk("t6_done_cycle", 32'(dat), 32'd25);
    req = '0;
`endif

    // Randomized traffic checked by the model every cycle.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      random_step();
    end
    req = '0;
    repeat (50) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
